// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
package uart_pkg;

   // Default half-bit period in clk cycles.
   localparam int CLK_PER_HALF_BIT_DEFAULT = 260;

   // Receive state machine states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module uart_sync2 (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops; reset to the idle-high level.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizes rxd, finds the start edge, samples mid-bit.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT
) (
   output logic [7:0] rdata,
   output logic       rx_ready,
   output logic       ferr,
   input  logic       rxd,
   input  logic       clk,
   input  logic       rstn
);

   localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_PER_HALF_BIT - 1);

   logic          rxs;
   logic          rxs_prev;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   uart_sync2 u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rxd),
      .q    (rxs)
   );

   // Receive FSM: half-bit wait to centre on the start bit, then whole-bit sample spacing.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rxs_prev <= 1'b1;
         rdata    <= '0;
         ferr     <= 1'b0;
         rx_ready <= 1'b0;
      end else begin
         rxs_prev <= rxs;
         rx_ready <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rxs_prev && !rxs) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt      <= '0;
                  rdata    <= shreg;
                  ferr     <= ~rxs;
                  rx_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
